// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Data wins arbitration, but a run counter bounds how long a pending fetch can starve.
module unified_mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_D_RUN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam logic [3:0] MAX_RUN = 4'(MAX_D_RUN);

  state_t              state_q, state_d;
  logic [3:0]          d_run_q, d_run_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                i_valid_q, i_valid_d;
  logic                d_valid_q, d_valid_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

  always_comb begin
    state_d     = state_q;
    d_run_d     = d_run_q;
    mem_req_d   = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_valid_d   = 1'b0;
    d_valid_d   = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      IDLE: begin
        // The run only grows while a fetch is actually waiting behind the data grants.
        if (d_req && (!i_req || d_run_q < MAX_RUN)) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          if (!i_req)
            d_run_d = '0;
          else if (d_run_q < MAX_RUN)
            d_run_d = d_run_q + 4'd1;
        end else if (i_req) begin
          state_d    = BUSY_I;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = i_addr;
          d_run_d    = '0;
        end
      end
      BUSY_I: begin
        if (mem_ack) begin
          state_d   = IDLE;
          i_valid_d = 1'b1;
          i_rdata_d = mem_rdata;
        end
      end
      BUSY_D: begin
        if (mem_ack) begin
          state_d   = IDLE;
          d_valid_d = 1'b1;
          if (!mem_we_q)
            d_rdata_d = mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      d_run_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_valid_q   <= 1'b0;
      d_valid_q   <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      d_run_q     <= d_run_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_valid_q   <= i_valid_d;
      d_valid_q   <= d_valid_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_valid   = i_valid_q;
  assign d_valid   = d_valid_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign stall_if  = i_req & ~i_valid_q;
  assign stall_mem = d_req & ~d_valid_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed scenarios plus a
// randomized run against a transaction-level arbitration model.
module tb_unified_mem_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXR = 4;

  logic          clk;
  logic          rst;
  logic          i_req, i_valid, d_req, d_we, d_valid;
  logic          stall_if, stall_mem, mem_req, mem_we, mem_ack;
  logic [AW-1:0] i_addr, d_addr, mem_addr;
  logic [DW-1:0] i_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;

  int n_vec = 0;
  int n_err = 0;

  // memory responder controls
  int mem_lat   = 1;
  bit mem_rand  = 0;
  bit stray_req = 0;
  int ack_cnt   = 0;

  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_RUN(MAXR)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h40) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Memory model: acks a command mem_lat cycles after its strobe, driven at +2
  // so that at +1 of the next cycle mem_ack still shows what the DUT sampled.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      mem_ack = 1'b0;
      if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_word(mem_addr);
        end
      end
      if (mem_req === 1'b1) ack_cnt = mem_rand ? int'($urandom_range(1, 4)) : mem_lat;
      if (stray_req) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hBADC0DE0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    n_vec++; if (mem_req !== 1'b0)   begin n_err++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
    n_vec++; if (mem_we !== 1'b0)    begin n_err++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    n_vec++; if (mem_addr !== '0)    begin n_err++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
    n_vec++; if (mem_wdata !== '0)   begin n_err++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
    n_vec++; if (i_valid !== 1'b0)   begin n_err++; $display("FAIL rst_i_valid: got %b want 0", i_valid); end
    n_vec++; if (d_valid !== 1'b0)   begin n_err++; $display("FAIL rst_d_valid: got %b want 0", d_valid); end
    n_vec++; if (i_rdata !== '0)     begin n_err++; $display("FAIL rst_i_rdata: got %h want 0", i_rdata); end
    n_vec++; if (d_rdata !== '0)     begin n_err++; $display("FAIL rst_d_rdata: got %h want 0", d_rdata); end
    n_vec++; if (stall_if !== 1'b0)  begin n_err++; $display("FAIL rst_stall_if: got %b want 0", stall_if); end
    n_vec++; if (stall_mem !== 1'b0) begin n_err++; $display("FAIL rst_stall_mem: got %b want 0", stall_mem); end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_single_load;
    mem_lat = 1;
    tick;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_wdata = '0;
    #1;
    n_vec++; if (stall_mem !== 1'b1) begin n_err++; $display("FAIL load_stall_c0: got %b want 1", stall_mem); end
    tick;
    n_vec++; if (mem_req !== 1'b1)     begin n_err++; $display("FAIL load_mem_req: got %b want 1", mem_req); end
    n_vec++; if (mem_addr !== 32'h40)  begin n_err++; $display("FAIL load_mem_addr: got %h want 40", mem_addr); end
    n_vec++; if (mem_we !== 1'b0)      begin n_err++; $display("FAIL load_mem_we: got %b want 0", mem_we); end
    n_vec++; if (stall_mem !== 1'b1)   begin n_err++; $display("FAIL load_stall_c1: got %b want 1", stall_mem); end
    tick;
    n_vec++; if (mem_req !== 1'b0)     begin n_err++; $display("FAIL load_mem_req_c2: got %b want 0", mem_req); end
    n_vec++; if (d_valid !== 1'b0)     begin n_err++; $display("FAIL load_early_valid: got %b want 0", d_valid); end
    n_vec++; if (stall_mem !== 1'b1)   begin n_err++; $display("FAIL load_stall_c2: got %b want 1", stall_mem); end
    tick;
    n_vec++; if (d_valid !== 1'b1)          begin n_err++; $display("FAIL load_valid: got %b want 1", d_valid); end
    n_vec++; if (d_rdata !== 32'hDEADBEEF)  begin n_err++; $display("FAIL load_rdata: got %h want deadbeef", d_rdata); end
    n_vec++; if (stall_mem !== 1'b0)        begin n_err++; $display("FAIL load_stall_c3: got %b want 0", stall_mem); end
    d_req = 1'b0;
    tick;
    n_vec++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL load_valid_pulse: got %b want 0", d_valid); end
  endtask

  task automatic test_store_latency;
    mem_lat = 5;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h12345678;
    tick;
    n_vec++; if (mem_req !== 1'b1)          begin n_err++; $display("FAIL st_mem_req: got %b want 1", mem_req); end
    n_vec++; if (mem_we !== 1'b1)           begin n_err++; $display("FAIL st_mem_we: got %b want 1", mem_we); end
    n_vec++; if (mem_addr !== 32'h80)       begin n_err++; $display("FAIL st_mem_addr: got %h want 80", mem_addr); end
    n_vec++; if (mem_wdata !== 32'h12345678) begin n_err++; $display("FAIL st_mem_wdata: got %h want 12345678", mem_wdata); end
    for (int k = 2; k <= 6; k++) begin
      tick;
      n_vec++; if (d_valid !== 1'b0 || mem_req !== 1'b0)
        begin n_err++; $display("FAIL st_wait_c%0d: valid=%b req=%b want 0/0", k, d_valid, mem_req); end
    end
    tick;
    n_vec++; if (d_valid !== 1'b1)          begin n_err++; $display("FAIL st_valid: got %b want 1", d_valid); end
    n_vec++; if (d_rdata !== 32'hDEADBEEF)  begin n_err++; $display("FAIL st_rdata_kept: got %h want deadbeef", d_rdata); end
    d_req = 1'b0; d_we = 1'b0;
    mem_lat = 1;
    tick;
  endtask

  task automatic test_contention;
    int run, grants, iv, dv, w;
    bit exp_d, got_d;
    run = 0; grants = 0; iv = 0; dv = 0; w = 0;
    mem_lat = 1;
    i_req = 1'b1; i_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    while (grants < 10 && w < 80) begin
      tick; w++;
      if (i_valid === 1'b1) iv++;
      if (d_valid === 1'b1) dv++;
      if (mem_req === 1'b1) begin
        exp_d = (run < MAXR);
        run   = exp_d ? run + 1 : 0;
        got_d = (mem_addr == 32'h200);
        n_vec++; if (got_d !== exp_d)
          begin n_err++; $display("FAIL cont_grant%0d: got %s want %s", grants, got_d ? "D" : "I", exp_d ? "D" : "I"); end
        grants++;
      end
    end
    n_vec++; if (grants != 10) begin n_err++; $display("FAIL cont_timeout: got %0d grants want 10", grants); end
    for (int k = 0; k < 2; k++) begin
      tick;
      if (i_valid === 1'b1) iv++;
      if (d_valid === 1'b1) dv++;
    end
    i_req = 1'b0; d_req = 1'b0;
    n_vec++; if (iv != 2) begin n_err++; $display("FAIL cont_i_valid_count: got %0d want 2", iv); end
    n_vec++; if (dv != 8) begin n_err++; $display("FAIL cont_d_valid_count: got %0d want 8", dv); end
    n_vec++; if (i_rdata !== mem_word(32'h100)) begin n_err++; $display("FAIL cont_i_rdata: got %h want %h", i_rdata, mem_word(32'h100)); end
    n_vec++; if (d_rdata !== mem_word(32'h200)) begin n_err++; $display("FAIL cont_d_rdata: got %h want %h", d_rdata, mem_word(32'h200)); end
    tick;
  endtask

  task automatic test_fetch_only;
    int cyc, last, w;
    cyc = 0; last = 0;
    mem_lat = 1;
    i_req = 1'b1; i_addr = 32'h0;
    for (int t = 0; t < 4; t++) begin
      w = 0;
      do begin tick; cyc++; w++; end while (mem_req !== 1'b1 && w < 10);
      n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL fetch_req_timeout%0d: got %b want 1", t, mem_req); end
      if (t > 0) begin
        n_vec++; if (cyc - last != 3) begin n_err++; $display("FAIL fetch_gap%0d: got %0d want 3", t, cyc - last); end
      end
      last = cyc;
      n_vec++; if (mem_we !== 1'b0)     begin n_err++; $display("FAIL fetch_we%0d: got %b want 0", t, mem_we); end
      n_vec++; if (mem_addr !== i_addr) begin n_err++; $display("FAIL fetch_addr%0d: got %h want %h", t, mem_addr, i_addr); end
      tick; tick; cyc += 2;
      n_vec++; if (i_valid !== 1'b1) begin n_err++; $display("FAIL fetch_valid%0d: got %b want 1", t, i_valid); end
      n_vec++; if (i_rdata !== mem_word(i_addr))
        begin n_err++; $display("FAIL fetch_rdata%0d: got %h want %h", t, i_rdata, mem_word(i_addr)); end
      if (t < 3) i_addr = i_addr + 32'h4;
      else       i_req = 1'b0;
    end
    tick;
  endtask

  task automatic test_reset_mid_op;
    mem_lat = 3;
    i_req = 1'b1; i_addr = 32'h300;
    tick;
    n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL rmid_mem_req: got %b want 1", mem_req); end
    tick;
    tick;
    rst = 1'b1; i_req = 1'b0;
    tick;
    rst = 1'b0;
    n_vec++; if ({mem_req, mem_we, i_valid, d_valid} !== 4'b0)
      begin n_err++; $display("FAIL rmid_flags: got %b want 0000", {mem_req, mem_we, i_valid, d_valid}); end
    n_vec++; if (mem_addr !== '0 || mem_wdata !== '0)
      begin n_err++; $display("FAIL rmid_mem_bus: got %h/%h want 0/0", mem_addr, mem_wdata); end
    n_vec++; if (i_rdata !== '0 || d_rdata !== '0)
      begin n_err++; $display("FAIL rmid_rdata: got %h/%h want 0/0", i_rdata, d_rdata); end
    tick;
    n_vec++; if (i_valid !== 1'b0 || mem_req !== 1'b0)
      begin n_err++; $display("FAIL rmid_late_ack: valid=%b req=%b want 0/0", i_valid, mem_req); end
    mem_lat = 1;
    i_req = 1'b1; i_addr = 32'h304;
    tick;
    n_vec++; if (mem_req !== 1'b1 || mem_addr !== 32'h304)
      begin n_err++; $display("FAIL rmid_next_req: req=%b addr=%h want 1/304", mem_req, mem_addr); end
    tick;
    tick;
    n_vec++; if (i_valid !== 1'b1 || i_rdata !== mem_word(32'h304))
      begin n_err++; $display("FAIL rmid_next_valid: valid=%b rdata=%h want 1/%h", i_valid, i_rdata, mem_word(32'h304)); end
    i_req = 1'b0;
    tick;
  endtask

  task automatic test_stray_ack;
    mem_lat = 1;
    stray_req = 1'b1;
    tick;
    stray_req = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      n_vec++; if ({i_valid, d_valid, mem_req} !== 3'b000)
        begin n_err++; $display("FAIL stray_c%0d: got iv/dv/req=%b want 000", k, {i_valid, d_valid, mem_req}); end
      tick;
    end
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
    tick;
    n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL stray_idle_req: got %b want 1", mem_req); end
    tick;
    tick;
    n_vec++; if (d_valid !== 1'b1 || d_rdata !== mem_word(32'h44))
      begin n_err++; $display("FAIL stray_next_valid: valid=%b rdata=%h want 1/%h", d_valid, d_rdata, mem_word(32'h44)); end
    d_req = 1'b0;
    tick;
  endtask

  // Transaction-level reference: each requester is either pending or not, the
  // memory is either owned by one of them or free, and a free memory is handed
  // out by the priority/starvation rule.
  task automatic test_random;
    bit i_pend, d_pend, busy, who_d, exp_req, exp_iv, exp_dv, g_we, dwe;
    int run;
    logic [31:0] g_addr, last_wdata, exp_ir, exp_dr, ia, da, dw;
    i_pend = 0; d_pend = 0; busy = 0; who_d = 0; exp_req = 0; g_we = 0; dwe = 0;
    run = 0;
    g_addr = '0; last_wdata = '0; exp_ir = '0; exp_dr = '0; ia = '0; da = '0; dw = '0;
    i_req = 1'b0; d_req = 1'b0; rst = 1'b1;
    mem_rand = 1'b1;
    tick;
    rst = 1'b0;
    for (int c = 0; c < 700; c++) begin
      tick;
      n_vec++; if (mem_req !== exp_req) begin n_err++; $display("FAIL rnd_mem_req@%0d: got %b want %b", c, mem_req, exp_req); end
      if (exp_req) begin
        n_vec++; if (mem_addr !== g_addr)      begin n_err++; $display("FAIL rnd_addr@%0d: got %h want %h", c, mem_addr, g_addr); end
        n_vec++; if (mem_we !== g_we)          begin n_err++; $display("FAIL rnd_we@%0d: got %b want %b", c, mem_we, g_we); end
        n_vec++; if (mem_wdata !== last_wdata) begin n_err++; $display("FAIL rnd_wdata@%0d: got %h want %h", c, mem_wdata, last_wdata); end
      end
      exp_iv = busy && (mem_ack === 1'b1) && !who_d;
      exp_dv = busy && (mem_ack === 1'b1) && who_d;
      if (exp_iv) exp_ir = mem_word(g_addr);
      if (exp_dv && !g_we) exp_dr = mem_word(g_addr);
      n_vec++; if (i_valid !== exp_iv) begin n_err++; $display("FAIL rnd_i_valid@%0d: got %b want %b", c, i_valid, exp_iv); end
      n_vec++; if (d_valid !== exp_dv) begin n_err++; $display("FAIL rnd_d_valid@%0d: got %b want %b", c, d_valid, exp_dv); end
      n_vec++; if (i_rdata !== exp_ir) begin n_err++; $display("FAIL rnd_i_rdata@%0d: got %h want %h", c, i_rdata, exp_ir); end
      n_vec++; if (d_rdata !== exp_dr) begin n_err++; $display("FAIL rnd_d_rdata@%0d: got %h want %h", c, d_rdata, exp_dr); end
      if (exp_iv || exp_dv) busy = 0;
      if (exp_iv) i_pend = 0;
      if (exp_dv) d_pend = 0;
      if (c < 600) begin
        if (!i_pend && $urandom_range(0, 2) == 0) begin
          i_pend = 1; ia = $urandom & 32'h0000FFFC;
        end
        if (!d_pend && $urandom_range(0, 1) == 0) begin
          d_pend = 1; dwe = 1'($urandom_range(0, 1)); da = $urandom & 32'h0001FFFC; dw = $urandom;
        end
      end
      i_req = i_pend; i_addr = ia;
      d_req = d_pend; d_we = dwe; d_addr = da; d_wdata = dw;
      exp_req = 0;
      if (!busy) begin
        if (d_pend && (!i_pend || run < MAXR)) begin
          exp_req = 1; busy = 1; who_d = 1;
          g_addr = da; g_we = dwe; last_wdata = dw;
          run = i_pend ? ((run < MAXR) ? run + 1 : MAXR) : 0;
        end else if (i_pend) begin
          exp_req = 1; busy = 1; who_d = 0;
          g_addr = ia; g_we = 0; run = 0;
        end
      end
      #1;
      n_vec++; if (stall_if !== (i_pend && !exp_iv))
        begin n_err++; $display("FAIL rnd_stall_if@%0d: got %b want %b", c, stall_if, i_pend && !exp_iv); end
      n_vec++; if (stall_mem !== (d_pend && !exp_dv))
        begin n_err++; $display("FAIL rnd_stall_mem@%0d: got %b want %b", c, stall_mem, d_pend && !exp_dv); end
    end
    n_vec++; if (i_pend || d_pend || busy)
      begin n_err++; $display("FAIL rnd_drain: got pending i/d/busy=%b%b%b want 000", i_pend, d_pend, busy); end
    mem_rand = 1'b0;
    i_req = 1'b0; d_req = 1'b0;
    tick;
  endtask

  initial begin
    rst = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    test_reset;
    test_single_load;
    test_store_latency;
    test_contention;
    test_fetch_only;
    test_reset_mid_op;
    test_stray_ack;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch (IF) stage and the data-access (MEM) stage of the 5-stage RISC-V pipeline.
- Sequences each access as a one-outstanding request/acknowledge transaction.
- Arbitrates between the two stages: data has priority, with a bounded fetch-starvation guard.
- Returns read data, and drives the stall signals that the hazard logic uses to freeze the stages.

Parameters:
- ADDR_W, 32, memory address width.
- DATA_W, 32, data width.
- MAX_D_RUN, 4, maximum consecutive data grants while a fetch is pending. Legal range 1..15.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  IF read request; held high until i_valid
- i_addr  in  ADDR_W  fetch address; stable while i_req
- i_valid  out  1  one-cycle pulse: i_rdata valid, fetch done
- i_rdata  out  DATA_W  fetched instruction
- d_req  in  1  MEM access request (memRead|memWrite); held until d_valid
- d_we  in  1  1 = store, 0 = load; stable while d_req
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_valid  out  1  one-cycle pulse: data access done
- d_rdata  out  DATA_W  load data
- stall_if  out  1  i_req & ~i_valid (combinational)
- stall_mem  out  1  d_req & ~d_valid (combinational)
- mem_req  out  1  one-cycle command strobe to memory
- mem_we  out  1  write enable, qualified by mem_req
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_ack  in  1  one-cycle completion pulse; earliest the cycle after mem_req
- mem_rdata  in  DATA_W  read data, valid with mem_ack

Behaviour:
- Reset (sync):
  - State = IDLE; d_run = 0.
  - mem_req, mem_we, i_valid, d_valid = 0.
  - mem_addr, mem_wdata, i_rdata, d_rdata = 0.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE, grant decision each cycle:
  - d_req & (~i_req | d_run < MAX_D_RUN) → grant D.
  - else i_req → grant I.
  - else stay IDLE.
- Grant D:
  - Register mem_req=1, mem_we=d_we, mem_addr=d_addr, mem_wdata=d_wdata.
  - Go BUSY_D.
  - d_run = i_req ? d_run+1 : 0, saturating at MAX_D_RUN.
- Grant I:
  - Register mem_req=1, mem_we=0, mem_addr=i_addr; mem_wdata unchanged.
  - Go BUSY_I; d_run = 0.
- mem_req is high exactly one cycle (the cycle after the grant decision). Addr/we/wdata hold until the next grant.
- BUSY_x, mem_ack=0: stay in BUSY_x.
- BUSY_x, mem_ack=1:
  - Next cycle: x_valid=1; return to IDLE.
  - i_rdata/d_rdata ← mem_rdata on reads only. A store leaves d_rdata unchanged.
- No back-to-back grant in the ack cycle. Minimum transaction: request seen at cycle t, mem_req at t+1, ack at t+2, valid at t+3. The next grant decision happens at t+3.
- Requester rule: a requester drops its req in the cycle x_valid is high, or keeps it high for a new access. The arbiter evaluates the new req starting in that same IDLE cycle. A req held through its valid cycle is a new request.
- mem_ack in IDLE (stray, or arriving after reset mid-transaction) is ignored: no valid pulse, no state change.
- rst asserted during BUSY_x:
  - Transaction is abandoned; no x_valid is ever produced for it.
  - Outputs take their reset values next cycle.
- Simultaneous first requests from IDLE with d_run=0 → D wins.
- After MAX_D_RUN consecutive D grants with i_req high throughout, the next grant goes to I even if d_req is high.
- All outputs are registered except stall_if and stall_mem.

Test Plan:
- Single load, ack latency 1: d_req=1, d_we=0, d_addr=0x40 at cycle 0 → mem_req=1, mem_addr=0x40, mem_we=0 at cycle 1. mem_ack with mem_rdata=0xDEADBEEF at cycle 2 → d_valid=1, d_rdata=0xDEADBEEF at cycle 3. stall_mem=1 for cycles 0-2.
- Store with 5-cycle ack latency: d_we=1, d_addr=0x80, d_wdata=0x12345678 → mem_we=1 and mem_wdata=0x12345678 for one mem_req cycle. d_valid 6 cycles after mem_req (ack at mem_req+5). d_rdata keeps its prior value.
- Contention: i_req and d_req both held continuously, MAX_D_RUN=4, ack latency 1 → grant sequence D,D,D,D,I,D,D,D,D,I. i_valid occurs exactly once per 5 transactions.
- Fetch only: i_req at 0x0, then 0x4 held back-to-back → mem_req every 3 cycles, i_rdata matches mem_rdata each time. mem_we=0 always.
- Reset mid-op: grant I, assert rst one cycle before mem_ack → no i_valid. All outputs 0 the cycle after rst. The late mem_ack is ignored; the next request proceeds normally.
- Stray ack: mem_ack pulse while IDLE with no requests → no valid pulses, no mem_req, state stays IDLE.
